// File: rtl/call_display_pkg.sv
// Shared definitions for the call display: FSM states, calling-counter codes,
// glyph codes fed to the scanner and their seven-segment patterns {g,f,e,d,c,b,a}.
package call_display_pkg;

  typedef enum logic [1:0] {IDLE, ANNOUNCE, SHOW} state_t;

  localparam logic [2:0] CTR_NONE = 3'd0;
  localparam logic [2:0] CTR_A    = 3'd1;
  localparam logic [2:0] CTR_B    = 3'd2;
  localparam logic [2:0] CTR_C    = 3'd3;
  localparam logic [2:0] CTR_D    = 3'd4;
  localparam logic [2:0] CTR_E    = 3'd5;

  // Glyph codes 0..9 are the decimal digits themselves.
  localparam logic [4:0] GLY_A     = 5'd10;
  localparam logic [4:0] GLY_B     = 5'd11;
  localparam logic [4:0] GLY_C     = 5'd12;
  localparam logic [4:0] GLY_D     = 5'd13;
  localparam logic [4:0] GLY_E     = 5'd14;
  localparam logic [4:0] GLY_DASH  = 5'd15;
  localparam logic [4:0] GLY_BLANK = 5'd16;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] glyph_to_seg(input logic [4:0] glyph);
    case (glyph)
      5'd0:     return SEG_0;
      5'd1:     return SEG_1;
      5'd2:     return SEG_2;
      5'd3:     return SEG_3;
      5'd4:     return SEG_4;
      5'd5:     return SEG_5;
      5'd6:     return SEG_6;
      5'd7:     return SEG_7;
      5'd8:     return SEG_8;
      5'd9:     return SEG_9;
      GLY_A:    return SEG_A;
      GLY_B:    return SEG_B;
      GLY_C:    return SEG_C;
      GLY_D:    return SEG_D;
      GLY_E:    return SEG_E;
      GLY_DASH: return SEG_DASH;
      default:  return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/call_display_seg_scan.sv
// Four-digit multiplexer for the call display: scan timer, digit select and glyph decode.
// seg and an are registered together so a digit never shows its neighbour's pattern.
module call_display_seg_scan #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] glyph3,
  input  logic [4:0] glyph2,
  input  logic [4:0] glyph1,
  input  logic [4:0] glyph0,
  input  logic       digits_off,
  output logic [6:0] seg,
  output logic [3:0] an
);
  import call_display_pkg::*;

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit;
  logic [1:0]        digit_next;
  logic              scan_last;
  logic [4:0]        glyph_next;

  assign scan_last = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    digit_next = scan_last ? digit + 2'd1 : digit;
    case (digit_next)
      2'd0:    glyph_next = glyph0;
      2'd1:    glyph_next = glyph1;
      2'd2:    glyph_next = glyph2;
      default: glyph_next = glyph3;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
      an       <= 4'b1110;
      seg      <= SEG_DASH;
    end else begin
      scan_cnt <= scan_last ? '0 : scan_cnt + SCAN_W'(1);
      digit    <= digit_next;
      an       <= digits_off ? 4'b1111 : ~(4'b0001 << digit_next);
      seg      <= glyph_to_seg(glyph_next);
    end
  end

endmodule

// File: rtl/call_display.sv
// Call display: detects new calls, queues them, announces each with a buzzer pulse and
// drives the 4-digit panel. Define BLINK_EN to blink the digits while announcing.
module call_display #(
  parameter int unsigned SCAN_DIV    = 16,
  parameter int unsigned HOLD_CYCLES = 100000000,
  parameter int unsigned BEEP_CYCLES = 25000000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned BLINK_DIV   = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] counter_call,
  input  logic [5:0] number_call,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] pending,
  output logic       overflow
);
  import call_display_pkg::*;

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [2:0]       prev_ctr;
  logic [5:0]       prev_num;
  logic             call_event;
  logic [2:0]       fifo_ctr [FIFO_DEPTH];
  logic [5:0]       fifo_num [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  state_t           state;
  state_t           next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic             hold_last;
  logic [2:0]       cur_ctr;
  logic [5:0]       cur_num;
  logic [4:0]       glyph3, glyph2, glyph1, glyph0;
  logic             digits_off;

  assign call_event = (counter_call >= CTR_A) && (counter_call <= CTR_E) &&
                      ({counter_call, number_call} != {prev_ctr, prev_num});
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push      = call_event && (!full || pop);
  assign hold_last = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
  assign pending   = 3'(count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_ctr <= CTR_NONE;
      prev_num <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      prev_ctr <= counter_call;
      prev_num <= number_call;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (call_event && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ctr[wr_ptr] <= counter_call;
      fifo_num[wr_ptr] <= number_call;
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE, SHOW: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = ANNOUNCE;
        end
      end
      ANNOUNCE: begin
        if (hold_last) begin
          if (!empty) pop = 1'b1;
          else next_state = SHOW;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // busy and buzzer are registered, so they line up with the registered panel outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      cur_ctr  <= CTR_NONE;
      cur_num  <= '0;
      busy     <= 1'b0;
      buzzer   <= 1'b0;
    end else begin
      state  <= next_state;
      busy   <= (state == ANNOUNCE);
      buzzer <= (state == ANNOUNCE) && (hold_cnt < HOLD_W'(BEEP_CYCLES));
      if (pop) begin
        cur_ctr  <= fifo_ctr[rd_ptr];
        cur_num  <= fifo_num[rd_ptr];
        hold_cnt <= '0;
      end else if (state == ANNOUNCE) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  always_comb begin
    glyph3 = GLY_DASH;
    glyph2 = GLY_DASH;
    glyph1 = GLY_DASH;
    glyph0 = GLY_DASH;
    if (state != IDLE) begin
      case (cur_ctr)
        CTR_A:   glyph3 = GLY_A;
        CTR_B:   glyph3 = GLY_B;
        CTR_C:   glyph3 = GLY_C;
        CTR_D:   glyph3 = GLY_D;
        CTR_E:   glyph3 = GLY_E;
        default: glyph3 = GLY_BLANK;
      endcase
      glyph2 = GLY_BLANK;
      glyph1 = 5'(cur_num / 6'd10);
      glyph0 = 5'(cur_num % 6'd10);
    end
  end

`ifdef BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_off;

  // Every pop enters ANNOUNCE afresh, so the blink restarts in its "on" half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (pop) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (state == ANNOUNCE) begin
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign digits_off = blink_off && (state == ANNOUNCE);
`else
  logic unused_blink_div;
  assign unused_blink_div = (BLINK_DIV != 0);
  assign digits_off       = 1'b0;
`endif

  call_display_seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk        (clk),
    .rst        (rst),
    .glyph3     (glyph3),
    .glyph2     (glyph2),
    .glyph1     (glyph1),
    .glyph0     (glyph0),
    .digits_off (digits_off),
    .seg        (seg),
    .an         (an)
  );

endmodule
